// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asyn_fifo write port among NREQ valid/ready requesters (wclk domain).
// Latency: grant one cycle after valid, winc one cycle after the accepted beat; wfull freezes the output register and drops req_ready.
// Optional stall counter output stall_cnt is built only when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  wfull
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    grant_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;

  logic               load_en;
  logic               beat;
  logic               owner_valid;
  logic               owner_last;
  logic [WIDTH-1:0]   sel_data;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   cand;

  // The output register can take a new word unless it holds one the FIFO refuses.
  assign load_en     = ~winc | ~wfull;
  assign req_ready   = (state == BURST && load_en) ? grant : '0;
  assign beat        = |(req_valid & req_ready);
  // rr_ptr doubles as the owner index while a burst is in progress.
  assign owner_valid = req_valid[rr_ptr];
  assign owner_last  = req_last[rr_ptr];
  assign sel_data    = req_data[rr_ptr*WIDTH +: WIDTH];

  // First valid requester after the previous winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (found) begin
          grant_nxt = NREQ'(1) << pick;
          rr_nxt    = pick;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
        if (!owner_valid ||
            (beat && (owner_last || beat_cnt == CNT_W'(BURST_MAX - 1)))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= PTR_W'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // A word stuck behind wfull keeps winc/wdata stable until the FIFO takes it.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      winc  <= 1'b0;
      wdata <= '0;
    end else if (load_en) begin
      winc <= beat;
      if (beat) begin
        wdata <= sel_data;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      stall_cnt <= '0;
    end else if (winc && wfull && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues drive the ports, a negedge monitor
// checks FIFO writes and grant/burst/idle-gap sequences against hand-computed scoreboards.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic                  winc;
  logic [WIDTH-1:0]      wdata;
  logic                  wfull;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]           stall_cnt;
`endif

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_MAX(4)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } word_t;

  typedef struct {
    logic [3:0] g;
    int         beats;
    int         gap;
  } gitem_t;

  word_t        dq[NREQ][$];
  logic [7:0]   exp_w[$];
  gitem_t       exp_g[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit l);
    word_t w;
    w.d = d;
    w.l = l;
    dq[i].push_back(w);
  endtask

  task automatic push_g(input logic [3:0] g, input int beats, input int gap);
    gitem_t it;
    it.g     = g;
    it.beats = beats;
    it.gap   = gap;
    exp_g.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((dq[0].size() + dq[1].size() + dq[2].size() + dq[3].size() != 0 ||
            grant != 0 || winc || exp_w.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    check({nm, "_drain_timeout"}, 32'(n >= 300), 32'd0);
    tick(2);
    check({nm, "_grants_left"}, exp_g.size(), 0);
  endtask

  // Requester model: pops a head word after each accepted beat.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (dq[i].size() > 0) begin
        req_valid[i]             = 1'b1;
        req_data[i*WIDTH +: WIDTH] = dq[i][0].d;
        req_last[i]              = dq[i][0].l;
      end else begin
        req_valid[i]             = 1'b0;
        req_data[i*WIDTH +: WIDTH] = '0;
        req_last[i]              = 1'b0;
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge wclk);
      acc = req_valid & req_ready;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      end
      drive();
      #2;
      drive();
    end
  end

  // Monitor: FIFO writes, grant order, beats per grant, idle cycles between grants.
  logic [3:0] prev_g = '0;
  bit         cur_act = 0;
  gitem_t     cur;
  int         beats = 0;
  int         gap_cnt = 0;

  always @(negedge wclk) begin
    if (wrst) begin
      cur_act = 0;
      prev_g  = '0;
      gap_cnt = 0;
    end else begin
      if (winc && !wfull) begin
        if (exp_w.size() == 0) begin
          check("unexpected_write", {24'd0, wdata}, 32'hFFFF_FFFF);
        end else begin
          check("fifo_wdata", {24'd0, wdata}, {24'd0, exp_w.pop_front()});
        end
      end
      if (grant != prev_g) begin
        if (prev_g != 0 && cur_act) begin
          check("beats_per_grant", beats, cur.beats);
          cur_act = 0;
        end
        if (grant != 0) begin
          if (exp_g.size() == 0) begin
            check("unexpected_grant", {28'd0, grant}, 32'hFFFF_FFFF);
          end else begin
            cur = exp_g.pop_front();
            cur_act = 1;
            check("grant_order", {28'd0, grant}, {28'd0, cur.g});
            if (cur.gap >= 0) check("idle_gap", gap_cnt, cur.gap);
          end
          beats = 0;
        end else begin
          gap_cnt = 1;
        end
      end else if (grant == 0) begin
        gap_cnt++;
      end
      if (grant != 0) beats += $countones(req_valid & req_ready);
      prev_g = grant;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst  = 1'b1;
    wfull = 1'b0;
    tick(2);
    check("rst_winc", {31'd0, winc}, 32'd0);
    check("rst_wdata", {24'd0, wdata}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
`ifdef FIFO_ARB_STATS_EN
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    wrst = 1'b0;
    tick(2);

    // Single packet from req0.
    send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 1);
    exp_w.push_back(8'h01); exp_w.push_back(8'h02); exp_w.push_back(8'h03);
    push_g(4'b0001, 3, -1);
    tick(1);
    check("t2_grant_latency", {28'd0, grant}, 32'b0001);
    check("t2_ready_in_grant_cycle", {28'd0, req_ready}, 32'b0001);
    tick(1);
    check("t2_winc_1", {31'd0, winc}, 32'd1);
    check("t2_wdata_1", {24'd0, wdata}, 32'h01);
    tick(1);
    check("t2_wdata_2", {24'd0, wdata}, 32'h02);
    tick(1);
    check("t2_wdata_3", {24'd0, wdata}, 32'h03);
    check("t2_grant_released", {28'd0, grant}, 32'd0);
    tick(1);
    check("t2_winc_done", {31'd0, winc}, 32'd0);
    wait_idle("t2");

    // Round robin, all four busy, rr_ptr left at 0 by req0.
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 5; k++) send(i, 8'((i << 4) | k), 0);
    end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) exp_w.push_back(8'((((j + 1) % 4) << 4) | k));
    end
    for (int j = 0; j < 4; j++) exp_w.push_back(8'((((j + 1) % 4) << 4) | 4));
    push_g(4'b0010, 4, -1); push_g(4'b0100, 4, 1); push_g(4'b1000, 4, 1); push_g(4'b0001, 4, 1);
    push_g(4'b0010, 1, 1);  push_g(4'b0100, 1, 1); push_g(4'b1000, 1, 1); push_g(4'b0001, 1, 1);
    wait_idle("t3");

    // Backpressure: five full cycles after two beats of req2.
    for (int k = 0; k < 6; k++) begin
      send(2, 8'(8'hA0 + k), k == 5);
      exp_w.push_back(8'(8'hA0 + k));
    end
    push_g(4'b0100, 4, -1); push_g(4'b0100, 2, 1);
    tick(3);
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_winc_frozen", {31'd0, winc}, 32'd1);
      check("t4_wdata_frozen", {24'd0, wdata}, 32'hA1);
      check("t4_ready_blocked", {28'd0, req_ready}, 32'd0);
      tick(1);
    end
    wfull = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    check("t4_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
    wait_idle("t4");

    // req1 releases after two beats; req2 takes over after one idle cycle.
    send(1, 8'h50, 0); send(1, 8'h51, 0);
    send(2, 8'h60, 0); send(2, 8'h61, 0); send(2, 8'h62, 1);
    exp_w.push_back(8'h50); exp_w.push_back(8'h51);
    exp_w.push_back(8'h60); exp_w.push_back(8'h61); exp_w.push_back(8'h62);
    push_g(4'b0010, 2, -1); push_g(4'b0100, 3, 1);
    wait_idle("t5");

    // last on beat BURST_MAX-1 gives a single exit.
    for (int k = 0; k < 4; k++) begin
      send(3, 8'(8'h70 + k), k == 3);
      exp_w.push_back(8'(8'h70 + k));
    end
    send(0, 8'h80, 1);
    exp_w.push_back(8'h80);
    push_g(4'b1000, 4, -1); push_g(4'b0001, 1, 1);
    wait_idle("t5b");

`ifdef FIFO_ARB_STATS_EN
    send(3, 8'hC3, 1);
    exp_w.push_back(8'hC3);
    push_g(4'b1000, 1, -1);
    tick(3);
    wfull = 1'b1;
    tick(70000);
    check("t6_stall_saturated", {16'd0, stall_cnt}, 32'hFFFF);
    wfull = 1'b0;
    wait_idle("t6");
`endif

    // Reset in the middle of a req1 burst.
    for (int k = 0; k < 6; k++) send(1, 8'(8'hB0 + k), 0);
    exp_w.push_back(8'hB0);
    push_g(4'b0010, 0, -1);
    tick(3);
    wrst = 1'b1;
    #1;
    check("t1_rst_winc", {31'd0, winc}, 32'd0);
    check("t1_rst_wdata", {24'd0, wdata}, 32'd0);
    check("t1_rst_grant", {28'd0, grant}, 32'd0);
    check("t1_rst_ready", {28'd0, req_ready}, 32'd0);
`ifdef FIFO_ARB_STATS_EN
    check("t1_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    check("t1_pre_rst_writes", exp_w.size(), 0);
    for (int i = 0; i < NREQ; i++) dq[i].delete();
    exp_g.delete();
    tick(2);
    wrst = 1'b0;
    tick(1);
    send(0, 8'hD0, 1); send(2, 8'hD2, 1);
    exp_w.push_back(8'hD0); exp_w.push_back(8'hD2);
    push_g(4'b0001, 1, -1); push_g(4'b0100, 1, 1);
    wait_idle("t1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
